// File: rtl/add_serial_sched_pkg.sv
// add_serial_sched_pkg: shared state encoding and default sizing for the serial-add scheduler.
package add_serial_sched_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 4;
    localparam int CNT_W     = $clog2(DEF_WIDTH);
    localparam int SEL_W     = $clog2(DEF_NREQ);
endpackage

// File: rtl/add_serial_sched_core.sv
// serial_add_core: LSB-first bit-serial adder; operands load on start, one bit per cycle while busy.
module serial_add_core import add_serial_sched_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d, s, maj;
    always_comb begin
        s       = a_q[0] ^ b_q[0] ^ carry_q;
        maj     = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        a_d     = start ? a : busy ? a_q >> 1 : a_q;
        b_d     = start ? b : busy ? b_q >> 1 : b_q;
        acc_d   = start ? '0 : busy ? {s, acc_q[WIDTH-1:1]} : acc_q;
        carry_d = start ? 1'b0 : busy ? maj : carry_q;
        count_d = start ? '0 : busy ? count_q + CW'(1) : count_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end
    // sum/cout are the values the final ADD cycle is about to commit
    assign last = count_q == CW'(WIDTH - 1);
    assign sum  = {s, acc_q[WIDTH-1:1]};
    assign cout = maj;
endmodule

// File: rtl/add_serial_sched.sv
// add_serial_sched: round-robin scheduler sharing one bit-serial adder among NREQ requesters.
module add_serial_sched import add_serial_sched_pkg::*; #(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a,
    input  logic [NREQ*WIDTH-1:0] b,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result,
    output logic                  cout,
    output logic                  busy
);
    localparam int SW = $clog2(NREQ);
    localparam int CW = $clog2(WIDTH);
    state_t            state_q, state_d;
    logic [SW-1:0]     ptr_q, ptr_d, sel_q, sel_d, win;
    logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d;
    logic [WIDTH-1:0]  result_q, result_d, core_sum;
    logic              cout_q, cout_d, core_cout, core_last, start;
    // scanning from the far end keeps the nearest set bit after ptr
    always_comb begin
        win = '0;
        for (int i = NREQ; i >= 1; i--)
            if (req[(int'(ptr_q) + i) % NREQ]) win = SW'((int'(ptr_q) + i) % NREQ);
    end
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        done_d   = '0;
        result_d = result_q;
        cout_d   = cout_q;
        start    = 1'b0;
        case (state_q)
            IDLE: if (|req) begin
                start   = 1'b1;
                sel_d   = win;
                state_d = ADD;
            end
            ADD: if (core_last) begin
                state_d      = DONE;
                result_d     = core_sum;
                cout_d       = core_cout;
                done_d[sel_q] = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = sel_q;
            end
            default: state_d = IDLE;
        endcase
        gnt_d = start ? NREQ'(1) << win : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= SW'(NREQ - 1);
            sel_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end
    serial_add_core #(.WIDTH(WIDTH), .CW(CW)) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a[int'(win)*WIDTH +: WIDTH]),
        .b     (b[int'(win)*WIDTH +: WIDTH]),
        .busy  (state_q == ADD),
        .last  (core_last),
        .sum   (core_sum),
        .cout  (core_cout)
    );
    assign gnt    = gnt_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign busy   = state_q != IDLE;
endmodule

// File: tb/tb_add_serial_sched.sv
// tb_add_serial_sched: directed + randomized checks of arbitration order, timing and sums.
module tb_add_serial_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a, b;
    logic [NREQ-1:0]       gnt, done;
    logic [WIDTH-1:0]      result;
    logic                  cout, busy;
    int n_vec = 0, n_err = 0, cyc = 0, mptr, last_g;
    bit chk_sp;
    add_serial_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req(req), .a(a), .b(b),
        .gnt(gnt), .done(done), .result(result), .cout(cout), .busy(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // round-robin rule: first set request strictly after the last served one
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 1; i <= NREQ; i++) if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return 0;
    endfunction
    task automatic set_op(input int i, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        a[i*WIDTH +: WIDTH] = av;
        b[i*WIDTH +: WIDTH] = bv;
    endtask
    // mode 0: drop all requests at grant, 1: drop the winner, 2: keep requesting
    task automatic run_one(input int mode);
        int wc = 0, w;
        logic [WIDTH:0] e;
        do begin @(negedge clk); wc++; end while (gnt === '0 && wc < 40);
        check("gnt_seen", 32'(gnt !== '0), 1);
        w = pick(req, mptr);
        check("gnt", 32'(gnt), 32'd1 << w);
        if (chk_sp && last_g >= 0) check("spacing", cyc - last_g, WIDTH + 2);
        last_g = cyc;
        e = {1'b0, a[w*WIDTH +: WIDTH]} + {1'b0, b[w*WIDTH +: WIDTH]};
        if (mode == 0) req = '0;
        else if (mode == 1) req[w] = 1'b0;
        set_op(w, WIDTH'($urandom), WIDTH'($urandom));
        mptr = w;
        repeat (WIDTH - 1) begin
            @(negedge clk);
            check("done_early", 32'(done), 0);
            check("busy_add", 32'(busy), 1);
        end
        @(negedge clk);
        check("done", 32'(done), 32'd1 << w);
        check("result", 32'(result), 32'(e[WIDTH-1:0]));
        check("cout", 32'(cout), 32'(e[WIDTH]));
        @(negedge clk);
        check("done_clr", 32'(done), 0);
        check("busy_idle", 32'(busy), 0);
        check("result_hold", 32'(result), 32'(e[WIDTH-1:0]));
    endtask
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_result", 32'(result), 0);
        check("rst_cout", 32'(cout), 0);
        check("rst_busy", 32'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mptr = NREQ - 1;
        last_g = -1;
    endtask
    initial begin
        req = '0; a = '0; b = '0; chk_sp = 1'b0; last_g = -1;
        @(negedge clk);
        do_reset();
        set_op(0, 8'h25, 8'h13); req = 4'b0001; run_one(0);
        set_op(2, 8'hFF, 8'h01); req = 4'b0100; run_one(0);
        set_op(2, 8'hFF, 8'hFF); req = 4'b0100; run_one(0);
        for (int k = 0; k < 8; k++) begin
            int i = $urandom_range(0, NREQ - 1);
            set_op(i, WIDTH'($urandom), WIDTH'($urandom));
            req = NREQ'(1) << i;
            run_one(0);
        end
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'($urandom), WIDTH'($urandom));
            req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            run_one(0);
        end
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'($urandom), WIDTH'($urandom));
        chk_sp = 1'b1;
        req = '1;
        repeat (NREQ) run_one(1);
        last_g = -1;
        req = 4'b0101;
        repeat (3) run_one(2);
        run_one(0);
        chk_sp = 1'b0;
        set_op(1, 8'h5A, 8'hC3); req = 4'b0010; run_one(0);
        set_op(0, 8'h77, 8'h99); req = 4'b0001;
        @(negedge clk);
        check("abort_gnt", 32'(gnt), 1);
        req = '0;
        repeat (3) @(negedge clk);
        check("abort_busy", 32'(busy), 1);
        do_reset();
        repeat (12) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 0);
        end
        set_op(3, WIDTH'($urandom), WIDTH'($urandom)); req = 4'b1000; run_one(0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
